mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multicycle sequencing FSM for the MIPS datapath: it replaces the single-cycle `control` decode with a per-instruction state sequence, so one ALU and one unified memory port are reused across cycles. It drives the PC, instruction-register, register-file, ALU-operand and memory strobes. It waits on a memory-ready handshake and counts retired instructions. It sits beside the datapath and takes the opcode from the instruction register.

## Interface
- No parameters.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  instruction[31:26] from the instruction register.
- `mem_ready`  in  1  memory completed the current read or write in this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`, `BranchNe`  out  1 each  datapath strobes and selects.
- `ALUSrcB`  out  2  00 = ReadData2, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ula_operation`  out  3  000 = add, 001 = subtract, 010 = funct-decoded.
- `state`  out  4  current state encoding, for debug.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ula_operation=000, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`; these are Mealy outputs.
  - Stay in FETCH while `mem_ready`=0. Go to DECODE when `mem_ready`=1.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ula_operation=000, so the branch target is computed into ALUOut.
  - Latch `opcode` into an internal `op_q`. All later states use `op_q`, never `opcode`.
  - Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq/bne→BRANCH, addi→ADDI_EXEC, j→JUMP.
  - Any other opcode: pulse `illegal_op`, go to FETCH, and do not count the instruction.
- **MEM_ADDR:** ALUSrcA=1, ALUSrcB=10, ula_operation=000. Next state is MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** MemRead=1, IorD=1. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB:** RegWrite=1, RegDst=0, MemtoReg=1. Next state FETCH (retire).
- **MEM_WRITE:** MemWrite=1, IorD=1, held until `mem_ready`. On `mem_ready` go to FETCH (retire).
- **R_EXEC:** ALUSrcA=1, ALUSrcB=00, ula_operation=010. Next state R_WB.
- **R_WB:** RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH (retire).
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ula_operation=001, PCWriteCond=1, PCSource=01, BranchNe=(op_q==000101). Next state FETCH (retire).
- **JUMP:** PCWrite=1, PCSource=10. Next state FETCH (retire).
- **ADDI_EXEC:** ALUSrcA=1, ALUSrcB=10, ula_operation=000. Next state ADDI_WB.
- **ADDI_WB:** RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH (retire).
- Any output not listed for a state is 0.
- `instr_count` increments by 1 on every retiring transition into FETCH. It wraps from 0xFFFFFFFF to 0 with no flag.
- Unused encodings 12–15 go to FETCH on the next edge, with no count and no `illegal_op`.

## Timing
- **Reset asserted:** state=FETCH, op_q=0, instr_count=0, illegal_op=0. All strobes are forced to 0 while reset is high: PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite. Other selects take their FETCH values.
- **Reset deasserted:** the first rising edge evaluates FETCH normally.
- **Reset mid-instruction:** the state machine aborts immediately, with no retire and no count. A pending MemWrite drops asynchronously.
- **Latency in cycles, counted from entering FETCH with `mem_ready` high at every wait:**
  - lw = 5
  - sw, R-type, addi = 4
  - beq, bne, j = 3
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs hold steady during the wait.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- `illegal_op` is high for exactly the one DECODE cycle. It is combinational from state and opcode.
- `instr_count` updates on the same edge that enters FETCH, so the new value is visible in the first FETCH cycle.

## Test plan
- **lw with mem_ready tied high:** state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_count goes 0→1.
- **sw with mem_ready low for 2 cycles in MEM_WRITE:** MemWrite is high for 3 consecutive cycles and state stays 5 until ready. Total of 6 cycles; count +1.
- **beq then bne:** BRANCH shows PCWriteCond=1, ula_operation=001, PCSource=01. BranchNe=0 for beq, 1 for bne. Each takes 3 cycles.
- **Opcode 111111:** illegal_op pulses for one cycle in DECODE, then state returns to 0. instr_count is unchanged and RegWrite and MemWrite never assert.
- **Reset asserted asynchronously in MEM_WRITE:** MemWrite drops before the next clock edge. state=0 and instr_count=0. After release, a normal fetch proceeds.
- **instr_count preset to 0xFFFFFFFF by retiring j instructions:** one more j wraps it to 0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencing FSM.
// Walks each instruction through fetch, decode and execute states so that one
// ALU and one unified memory port can be shared across cycles. Datapath
// strobes are decoded from the registered state. In FETCH, IRWrite and PCWrite
// also follow mem_ready in the same cycle. A retired-instruction counter
// advances on every retiring return to FETCH.
module mips_multicycle_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        BranchNe,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ula_operation,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t      state_q;
    logic [5:0]  op_q;
    logic [31:0] instr_count_q;

    // Raw strobes before the reset gate.
    logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
    logic ir_write_s, reg_write_s, illegal_s;

    // Sequencing: state transitions, opcode latch and retire counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            op_q          <= 6'd0;
            instr_count_q <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW:    state_q <= S_MEM_ADDR;
                        OP_R:            state_q <= S_R_EXEC;
                        OP_BEQ, OP_BNE:  state_q <= S_BRANCH;
                        OP_ADDI:         state_q <= S_ADDI_EXEC;
                        OP_J:            state_q <= S_JUMP;
                        default:         state_q <= S_FETCH;   // illegal: no retire
                    endcase
                end
                S_MEM_ADDR: begin
                    state_q <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    if (mem_ready) state_q <= S_MEM_WB;
                end
                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        state_q       <= S_FETCH;
                        instr_count_q <= instr_count_q + 32'd1;
                    end
                end
                S_R_EXEC:    state_q <= S_R_WB;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                    state_q       <= S_FETCH;
                    instr_count_q <= instr_count_q + 32'd1;
                end
                default: state_q <= S_FETCH;   // unused encodings recover silently
            endcase
        end
    end

    // Per-state output decode; anything not set for a state stays 0.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        illegal_s       = 1'b0;
        IorD            = 1'b0;
        MemtoReg        = 1'b0;
        ALUSrcA         = 1'b0;
        RegDst          = 1'b0;
        BranchNe        = 1'b0;
        ALUSrcB         = 2'b00;
        PCSource        = 2'b00;
        ula_operation   = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ALUSrcB    = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_s = 1'b0;
                    default:                                           illegal_s = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                IorD       = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                IorD        = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA       = 1'b1;
                ula_operation = 3'b010;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                RegDst      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA         = 1'b1;
                ula_operation   = 3'b001;
                pc_write_cond_s = 1'b1;
                PCSource        = 2'b01;
                BranchNe        = (op_q == OP_BNE);
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                PCSource   = 2'b10;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Strobes are gated by reset so that a mid-instruction write drops at once.
    assign PCWrite     = pc_write_s      & ~reset;
    assign PCWriteCond = pc_write_cond_s & ~reset;
    assign MemRead     = mem_read_s      & ~reset;
    assign MemWrite    = mem_write_s     & ~reset;
    assign IRWrite     = ir_write_s      & ~reset;
    assign RegWrite    = reg_write_s     & ~reset;
    assign illegal_op  = illegal_s       & ~reset;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule
